// File: rtl/uart_word_assembler.sv
// Pairs UART bytes into tagged 16-bit words (tag[15:12], payload[11:0]), rejects
// bad tags/reserved bits, resynchronises on errors and inter-byte timeout.
module uart_word_assembler #(
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter int          CNT_W          = 18,
    parameter logic [3:0]  MIN_TAG        = 4'h1,
    parameter logic [3:0]  MAX_TAG        = 4'h7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic [15:0] data,
    output logic        data_valid,
    output logic [7:0]  err_cnt,
    output logic        sync
);

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       TAG_CTRL   = 4'h7;

    state_t           r_state;
    logic [7:0]       r_hi;
    logic [CNT_W-1:0] r_timer;
    logic [15:0]      r_data;
    logic             r_data_valid;
    logic [7:0]       r_err_cnt;
    logic             r_sync;

    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_load_hi;
    logic             w_err_evt;
    logic             w_tag_ok;
    logic             w_reserved;
    logic [7:0]       w_hi_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [15:0]      w_data_nxt;
    logic [7:0]       w_err_nxt;

    assign w_tag_ok   = (rx_byte[7:4] >= MIN_TAG) && (rx_byte[7:4] <= MAX_TAG);
    assign w_reserved = (r_hi[7:4] == TAG_CTRL) && (r_hi[3:2] != 2'b00);

    // State and datapath registers; rst discards any partial word silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_HI;
            r_hi         <= 8'h00;
            r_timer      <= '0;
            r_data       <= 16'h0000;
            r_data_valid <= 1'b0;
            r_err_cnt    <= 8'h00;
            r_sync       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hi         <= w_hi_nxt;
            r_timer      <= w_timer_nxt;
            r_data       <= w_data_nxt;
            r_data_valid <= w_accept;
            r_err_cnt    <= w_err_nxt;
            r_sync       <= (w_state_nxt == WAIT_LO);
        end
    end

    // Next-state decode; a byte arriving on the timeout cycle is still the low byte.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_hi   = 1'b0;
        w_err_evt   = 1'b0;
        case (r_state)
            WAIT_HI: begin
                if (rx_done) begin
                    if (rx_err || !w_tag_ok) begin
                        w_err_evt = 1'b1;
                    end else begin
                        w_load_hi   = 1'b1;
                        w_state_nxt = WAIT_LO;
                    end
                end else begin
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (rx_done) begin
                    w_state_nxt = WAIT_HI;
                    if (rx_err || w_reserved) begin
                        w_err_evt = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt = WAIT_HI;
                    w_err_evt   = 1'b1;
                end else begin
                    w_state_nxt = WAIT_LO;
                end
            end
            default: begin
                w_state_nxt = WAIT_HI;
            end
        endcase
    end

    // Datapath next values: timer runs only while staying in WAIT_LO.
    always_comb begin
        w_hi_nxt    = w_load_hi ? rx_byte : r_hi;
        w_data_nxt  = w_accept ? {r_hi, rx_byte} : r_data;
        w_timer_nxt = '0;
        w_err_nxt   = r_err_cnt;
        if ((r_state == WAIT_LO) && (w_state_nxt == WAIT_LO)) begin
            w_timer_nxt = r_timer + CNT_W'(1);
        end else begin
            w_timer_nxt = '0;
        end
        if (w_err_evt && (r_err_cnt != 8'hFF)) begin
            w_err_nxt = r_err_cnt + 8'h01;
        end else begin
            w_err_nxt = r_err_cnt;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign err_cnt    = r_err_cnt;
    assign sync       = r_sync;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench: expected words are queued at stimulus time and popped by a
// monitor on every data_valid pulse; status outputs are checked at fixed points.
module tb_uart_word_assembler;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_done = 1'b0;
    logic        rx_err = 1'b0;
    logic [15:0] data;
    logic        data_valid;
    logic [7:0]  err_cnt;
    logic        sync;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    uart_word_assembler #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(5),
        .MIN_TAG(4'h1),
        .MAX_TAG(4'h7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_byte(rx_byte),
        .rx_done(rx_done),
        .rx_err(rx_err),
        .data(data),
        .data_valid(data_valid),
        .err_cnt(err_cnt),
        .sync(sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: byte is sampled on the next posedge, returns at the following negedge.
    task automatic send(input logic [7:0] b, input logic e);
        rx_byte = b;
        rx_done = 1'b1;
        rx_err  = e;
        @(negedge clk);
        rx_done = 1'b0;
        rx_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every data_valid cycle must consume exactly one expected word.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got data %h with no word expected", data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    failures++;
                    $display("FAIL word: got %h expected %h", data, e);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_data", data, 16'h0000);
        chk("rst_valid", {15'd0, data_valid}, 16'h0000);
        chk("rst_err", {8'd0, err_cnt}, 16'h0000);
        chk("rst_sync", {15'd0, sync}, 16'h0000);

        // Basic word
        exp_q.push_back(16'h15A3);
        send(8'h15, 1'b0);
        chk("t1_sync_hi", {15'd0, sync}, 16'h0001);
        send(8'hA3, 1'b0);
        chk("t1_data", data, 16'h15A3);
        chk("t1_valid", {15'd0, data_valid}, 16'h0001);
        chk("t1_err", {8'd0, err_cnt}, 16'h0000);
        chk("t1_sync_lo", {15'd0, sync}, 16'h0000);
        idle(1);
        chk("t1_valid_drop", {15'd0, data_valid}, 16'h0000);

        // Illegal tag resync
        do_reset();
        send(8'h95, 1'b0);
        chk("t2_err_tag", {8'd0, err_cnt}, 16'h0001);
        chk("t2_sync", {15'd0, sync}, 16'h0000);
        exp_q.push_back(16'h2140);
        send(8'h21, 1'b0);
        send(8'h40, 1'b0);
        chk("t2_data", data, 16'h2140);
        chk("t2_err", {8'd0, err_cnt}, 16'h0001);

        // Timeout
        do_reset();
        send(8'h3F, 1'b0);
        idle(T - 1);
        chk("t3_sync_before_to", {15'd0, sync}, 16'h0001);
        idle(1);
        chk("t3_sync_after_to", {15'd0, sync}, 16'h0000);
        chk("t3_err_to", {8'd0, err_cnt}, 16'h0001);
        chk("t3_data_held", data, 16'h0000);
        exp_q.push_back(16'h4412);
        send(8'h44, 1'b0);
        chk("t3_sync_44", {15'd0, sync}, 16'h0001);
        send(8'h12, 1'b0);
        chk("t3_data", data, 16'h4412);

        // Low byte on the exact timeout cycle wins
        send(8'h2A, 1'b0);
        idle(T - 1);
        exp_q.push_back(16'h2AB0);
        send(8'hB0, 1'b0);
        chk("tb_edge_data", data, 16'h2AB0);
        chk("tb_edge_err", {8'd0, err_cnt}, 16'h0001);

        // Tag 7 reserved bits
        send(8'h7C, 1'b0);
        send(8'h55, 1'b0);
        chk("t4_data_held", data, 16'h2AB0);
        chk("t4_err", {8'd0, err_cnt}, 16'h0002);
        chk("t4_sync", {15'd0, sync}, 16'h0000);
        exp_q.push_back(16'h7355);
        send(8'h73, 1'b0);
        send(8'h55, 1'b0);
        chk("t4_data", data, 16'h7355);

        // rx_err on low byte, then other discards
        do_reset();
        send(8'h61, 1'b0);
        send(8'h80, 1'b1);
        chk("t5_err", {8'd0, err_cnt}, 16'h0001);
        chk("t5_sync", {15'd0, sync}, 16'h0000);
        exp_q.push_back(16'h6200);
        send(8'h62, 1'b0);
        send(8'h00, 1'b0);
        chk("t5_data", data, 16'h6200);
        send(8'h21, 1'b1);
        chk("t5_err_hi_rxerr", {8'd0, err_cnt}, 16'h0002);
        send(8'h05, 1'b0);
        send(8'h8F, 1'b0);
        chk("t5_err_tag_bounds", {8'd0, err_cnt}, 16'h0004);
        chk("t5_sync_bounds", {15'd0, sync}, 16'h0000);

        // Saturation
        for (int i = 0; i < 300; i++) send(8'hF0, 1'b0);
        chk("t5_sat", {8'd0, err_cnt}, 16'h00FF);
        chk("t5_sat_data", data, 16'h6200);

        // Reset mid-word
        send(8'h51, 1'b0);
        chk("t6_sync_pre", {15'd0, sync}, 16'h0001);
        do_reset();
        chk("t6_data", data, 16'h0000);
        chk("t6_err", {8'd0, err_cnt}, 16'h0000);
        chk("t6_sync", {15'd0, sync}, 16'h0000);
        chk("t6_valid", {15'd0, data_valid}, 16'h0000);
        send(8'h22, 1'b0);
        chk("t6_sync_22", {15'd0, sync}, 16'h0001);
        idle(3);

        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Sits directly upstream of the UART demultiplexer on the receiving board.
- Takes the byte stream from the UART receiver, pairs bytes into tagged 16-bit words (tag in [15:12], payload in [11:0]), validates them and presents the last good word on a held `data` bus plus a one-cycle `data_valid` strobe.
- Provides resynchronisation after lost or corrupt bytes through tag checking and an inter-byte timeout, and counts errors for debug.

Parameters:
- TIMEOUT_CYCLES, 200000: maximum clk cycles allowed between the high and low byte of one word.
- CNT_W, 18: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- MIN_TAG, 4'h1: lowest legal tag value.
- MAX_TAG, 4'h7: highest legal tag value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  received byte; valid only while rx_done=1
- rx_done  in  1  one-cycle strobe, byte received
- rx_err  in  1  framing/parity error; qualified by rx_done
- data  out  16  last accepted word; held between updates
- data_valid  out  1  one-cycle pulse, asserted in the same cycle `data` first shows the new word
- err_cnt  out  8  saturating count of discarded bytes/words
- sync  out  1  1 while in WAIT_LO, i.e. a high byte is held

Behaviour:
- All state updates on posedge clk. rst is synchronous and active-high, and overrides all other inputs.
- Reset values:
  - data = 16'h0000 (tag 0 is ignored downstream)
  - data_valid = 0
  - err_cnt = 0
  - sync = 0
  - state = WAIT_HI
  - timer = 0
  - hi_reg = 0
- Byte order on the wire: high byte first (tag + payload[11:8]), then low byte (payload[7:0]).
- Two FSM states: WAIT_HI and WAIT_LO.
- WAIT_HI, when rx_done=1:
  - rx_err=1: discard the byte, err_cnt+1, stay in WAIT_HI.
  - rx_byte[7:4] outside [MIN_TAG, MAX_TAG]: discard the byte, err_cnt+1, stay in WAIT_HI. This is the resync mechanism.
  - Otherwise: hi_reg <= rx_byte, timer <= 0, go to WAIT_LO.
- WAIT_LO, when rx_done=1 and rx_err=0:
  - Tag 4'h7 (match control) with hi_reg[3:2] != 0: reserved bits set, reject the word, err_cnt+1, go to WAIT_HI.
  - Otherwise: data <= {hi_reg, rx_byte}, data_valid <= 1 for exactly one cycle, go to WAIT_HI.
- WAIT_LO, when rx_done=1 and rx_err=1: drop the partial word, err_cnt+1, go to WAIT_HI. The errored byte is not reinterpreted as a high byte.
- WAIT_LO, when rx_done=0:
  - timer increments by 1 each cycle.
  - When timer == TIMEOUT_CYCLES-1: go to WAIT_HI, err_cnt+1, timer <= 0.
- Simultaneous rx_done and timeout expiry in the same cycle: the byte wins, and it is processed as the low byte.
- The low byte value is never checked; any value 8'h00..8'hFF is legal.
- Latency: `data` and `data_valid` update on the first clk edge after the cycle in which the low byte's rx_done is sampled.
- data_valid: deasserted in every cycle other than the acceptance pulse. Back-to-back words therefore produce pulses no closer than the byte rate.
- err_cnt: saturates at 8'hFF, no wrap.
- Multiple error sources cannot occur in one cycle; at most +1 per cycle.
- `data` holds its value through errors, timeouts and rejected words. It changes only on acceptance or reset.
- Reset asserted mid-word (in WAIT_LO): the partial word is lost, no data_valid pulse, err_cnt not incremented, all registers return to their reset values.
- sync = (state == WAIT_LO), registered.

Test Plan:
- Send bytes 0x15, 0xA3 -> one cycle after the second rx_done: data=16'h15A3, data_valid=1 for exactly 1 cycle, err_cnt=0, sync back to 0.
- Send 0x95 (illegal tag 9), then 0x21, 0x40 -> err_cnt=1, data=16'h2140, exactly one data_valid pulse.
- Send 0x3F, then no byte for TIMEOUT_CYCLES cycles, then 0x44 and 0x12 -> timeout puts the FSM in WAIT_HI with err_cnt=1; 0x44 is taken as the high byte; data=16'h4412.
- Send 0x7C, 0x55 (tag 7 with reserved bits set) -> no data_valid, data unchanged, err_cnt+1. Then send 0x73, 0x55 -> data=16'h7355.
- Send 0x61, then 0x80 with rx_err=1, then 0x62, 0x00 -> partial word dropped, err_cnt=1, data=16'h6200. Separately, drive 300 illegal bytes -> err_cnt holds at 8'hFF.
- Send 0x51, then assert rst for 1 cycle, then send 0x22 -> all outputs at reset values; 0x22 is treated as a high byte and sync=1.
